sort_stream: RTL and testbench
==============================

Name: sort_stream

Overview:
- Sequential, parametrised successor to the team's 5-input combinational sorter.
- Accepts DEPTH unsigned numbers one per handshake and keeps them sorted on the fly using an insertion register array.
- Streams the sorted sequence out with valid/ready backpressure, in ascending or descending order selected per batch.
- Sits between a serial producer and any consumer needing ordered data, e.g. median or rank extraction.

Parameters:
- WIDTH, 6: bit width of each number, unsigned.
- DEPTH, 5: numbers per batch; legal range 1..64.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_num/in_mode valid this cycle.
- in_num  in  WIDTH  input number.
- in_mode  in  1  0 = ascending, 1 = descending; sampled only with the first element of a batch.
- in_ready  out  1  block can accept an input this cycle.
- out_valid  out  1  out_num holds a sorted element.
- out_num  out  WIDTH  current sorted element; 0 when out_valid = 0.
- out_last  out  1  high with the final element of the batch.
- out_ready  in  1  consumer accepts out_num this cycle.

Behaviour:
- Reset: while rst_n = 0, asynchronously:
  - state = IDLE; array, count and mode cleared.
  - out_valid = 0, out_num = 0, out_last = 0.
  - Inputs are ignored.
- Reset mid-batch discards all partial data; no output follows.
- in_ready is combinational from state: 1 in IDLE/LOAD, 0 in OUT.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- FSM states IDLE, LOAD, OUT:
  - IDLE:
    - On accept, latch in_mode into mode, write in_num to slot 0, set count = 1.
    - Next state is LOAD, or OUT if DEPTH == 1.
  - LOAD:
    - Each accept inserts in_num and increments count.
    - The accept that makes count == DEPTH moves to OUT on the next edge.
    - in_valid gaps of any length are allowed.
  - OUT:
    - out_valid = 1, out_num = slot 0, out_last = (remaining == 1).
    - Each emit shifts the array down one slot and decrements remaining.
    - The emit with out_last moves to IDLE.
    - out_num and out_last hold stable while out_ready = 0.
    - in_valid is ignored.
- Insertion in one cycle:
  - Each occupied slot compares against in_num, unsigned.
  - Ascending: slots holding a value <= in_num stay; all later slots shift up one; in_num fills the gap.
  - Descending: same rule with >=.
  - Equal values keep arrival order (stable). The occupied region is always sorted.
- Latency:
  - Last input accepted at edge t → out_valid high in the cycle after edge t.
  - With out_ready held high, one element per cycle; DEPTH output cycles total.
- Back-to-back batches:
  - in_ready returns in the cycle after the last emit.
  - No input is accepted in the same cycle as the last emit.
- The value of in_mode is irrelevant after the first element of a batch.
- count, remaining: $clog2(DEPTH+1) bits; no wrap is possible because the FSM caps them at DEPTH.

Decomposition:
- Package sort_pkg:
  - typedef enum logic [1:0] {IDLE, LOAD, OUT} sort_state_e.
  - typedef enum logic {ASCEND, DESCEND} sort_mode_e.
- Sub-module sort_insert_cell, instantiated DEPTH times:
  - Holds one slot.
  - Inputs: own value, lower neighbour value, in_num, mode, occupied flag, load/shift controls.
  - Outputs: "stay" compare bit and next slot value.
- The top level holds the FSM, counters and output muxing.

Test Plan (WIDTH=6, DEPTH=5):
- Ascending, in_mode=0: in 12,3,45,3,0 back-to-back, out_ready=1 → out 0,3,3,12,45 on 5 consecutive cycles; out_last only with 45; out_valid rises the cycle after the 0 is accepted.
- Descending, in_mode=1: in 63,0,31,31,7 with 2-cycle in_valid gaps → out 63,31,31,7,0; in_mode toggled on inputs 2-5 has no effect.
- Backpressure: out_ready low for 3 cycles while out_num=0 → out_num stays 0, out_valid stays 1; the sequence resumes unchanged, with no loss or duplication.
- Reset mid-load: after 3 inputs, pulse rst_n low asynchronously between edges → out_valid=0, out_num=0 immediately; next batch 5,4,3,2,1 ascending → 1,2,3,4,5.
- Boundary values: all inputs 63 → five outputs of 63; inputs 0,63,0,63,0 ascending → 0,0,0,63,63.
- in_valid held high during OUT → ignored; in_ready=0 throughout OUT; the next batch starts only after the out_last handshake.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types for the streaming insertion sorter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    OUT
  } sort_state_e;

  typedef enum logic {
    ASCEND,
    DESCEND
  } sort_mode_e;

endpackage

// File: rtl/sort_insert_cell.sv
// One slot of the insertion array: keeps, takes in_num, shifts up on insert, or shifts down on emit.
// Latency: slot value updates on the clock edge of the load/shift pulse; stay is combinational.
// Backpressure: none; the parent only pulses load/shift on completed handshakes.
//
// Ports: clk, rst_n; in_num/mode (value being inserted, batch order); occupied (slot holds data);
//        lower_stay/lower_val (slot i-1), upper_val (slot i+1); load (insert), shift (emit);
//        stay (slot keeps its value on insert), slot_val (registered slot contents).
module sort_insert_cell
  import sort_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_num,
  input  sort_mode_e       mode,
  input  logic             occupied,
  input  logic             lower_stay,
  input  logic [WIDTH-1:0] lower_val,
  input  logic [WIDTH-1:0] upper_val,
  input  logic             load,
  input  logic             shift,
  output logic             stay,
  output logic [WIDTH-1:0] slot_val
);

  // A slot stays when its value sorts no later than in_num; using <= / >=
  // puts a new equal value after existing ones, keeping arrival order.
  always_comb begin
    stay = 1'b0;
    if (occupied) begin
      stay = (mode == DESCEND) ? (slot_val >= in_num) : (slot_val <= in_num);
    end
  end

  // Because the occupied region is sorted, stay bits form a prefix: the first
  // non-staying slot (its lower neighbour stays) is the gap for in_num, and
  // every slot above it takes its lower neighbour's value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_val <= '0;
    end else if (shift) begin
      slot_val <= upper_val;
    end else if (load && !stay) begin
      slot_val <= lower_stay ? in_num : lower_val;
    end
  end

endmodule

// File: rtl/sort_stream.sv
// Streaming sorter: collects DEPTH unsigned numbers into a sorted register array, then streams them out.
// Latency: first sorted element valid the cycle after the last input is accepted; one element per cycle after.
// Backpressure: in_ready low while streaming out; output holds stable while out_ready is low.
//
// Ports: clk, rst_n (async, active low); in_valid/in_num/in_mode/in_ready (input handshake,
//        in_mode sampled with a batch's first element); out_valid/out_num/out_last/out_ready
//        (output handshake, out_num forced to 0 when idle).
module sort_stream
  import sort_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_num,
  input  logic             in_mode,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_num,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  sort_state_e      state_q, state_d;
  sort_mode_e       mode_q;
  // Counts stored elements while loading, then counts remaining elements
  // while streaming out; both phases never overlap so one register serves.
  logic [CW-1:0]    count_q;
  logic             accept, emit;
  logic [DEPTH-1:0] stay;
  logic [WIDTH-1:0] slot_val [DEPTH];

  assign in_ready  = (state_q != OUT);
  assign out_valid = (state_q == OUT);
  assign out_num   = out_valid ? slot_val[0] : '0;
  assign out_last  = out_valid && (count_q == CW'(1));
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (DEPTH == 1) ? OUT : LOAD;
      LOAD: if (accept && (count_q + CW'(1) == CW'(DEPTH))) state_d = OUT;
      OUT:  if (emit && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= ASCEND;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          mode_q  <= sort_mode_e'(in_mode);
          count_q <= CW'(1);
        end
        LOAD: if (accept) count_q <= count_q + CW'(1);
        OUT:  if (emit)   count_q <= count_q - CW'(1);
        default: count_q <= '0;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic             lower_stay;
    logic [WIDTH-1:0] lower_val;
    logic [WIDTH-1:0] upper_val;

    // Slot 0 sees a virtual lower neighbour that always stays, so it is the
    // gap whenever its own value moves up (or it is empty).
    if (i == 0) begin : g_first
      assign lower_stay = 1'b1;
      assign lower_val  = '0;
    end else begin : g_inner
      assign lower_stay = stay[i-1];
      assign lower_val  = slot_val[i-1];
    end

    // The top slot refills with zero on emit, leaving a clean array at batch end.
    if (i == DEPTH - 1) begin : g_top
      assign upper_val = '0;
    end else begin : g_below
      assign upper_val = slot_val[i+1];
    end

    sort_insert_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_num    (in_num),
      .mode      (mode_q),
      .occupied  (count_q > CW'(i)),
      .lower_stay(lower_stay),
      .lower_val (lower_val),
      .upper_val (upper_val),
      .load      (accept),
      .shift     (emit),
      .stay      (stay[i]),
      .slot_val  (slot_val[i])
    );
  end

endmodule

// File: tb/tb_sort_stream.sv
// Directed bench for sort_stream (WIDTH=6, DEPTH=5) with hand-computed expected outputs.
// Latency: inputs driven and outputs sampled on the falling edge, DUT acts on the rising edge.
// Backpressure: exercises out_ready stalls and in_valid held high while streaming.
module tb_sort_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] in_num;
  logic       in_mode;
  logic       in_ready;
  logic       out_valid;
  logic [5:0] out_num;
  logic       out_last;
  logic       out_ready;

  int tests = 0;
  int fails = 0;

  sort_stream #(
    .WIDTH(6),
    .DEPTH(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_num   (in_num),
    .in_mode  (in_mode),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_num  (out_num),
    .out_last (out_last),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one input for one cycle; called on a falling edge, returns on the next.
  task automatic push(input int n, input logic m);
    check("in_ready_load", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_num   = n[5:0];
    in_mode  = m;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Check one output element presented this cycle (out_ready assumed high).
  task automatic pop(input string tag, input int n, input logic last);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_num"},   32'(out_num),   32'(n));
    check({tag, "_last"},  32'(out_last),  32'(last));
    check({tag, "_inrdy"}, 32'(in_ready),  32'd0);
    @(negedge clk);
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_valid0"}, 32'(out_valid), 32'd0);
    check({tag, "_num0"},   32'(out_num),   32'd0);
    check({tag, "_ready1"}, 32'(in_ready),  32'd1);
  endtask

  // Asynchronous reset pulse placed between clock edges, checked while held.
  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_num"},   32'(out_num),   32'd0);
    check({tag, "_last"},  32'(out_last),  32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_num    = '0;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_num",   32'(out_num),   32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Ascending, back-to-back input, streaming output.
    push(12, 1'b0); push(3, 1'b0); push(45, 1'b0); push(3, 1'b0); push(0, 1'b0);
    pop("asc0", 0, 1'b0);
    pop("asc1", 3, 1'b0);
    pop("asc2", 3, 1'b0);
    pop("asc3", 12, 1'b0);
    pop("asc4", 45, 1'b1);
    idle_check("asc_end");

    // Descending with 2-cycle gaps; in_mode toggled after the first element.
    push(63, 1'b1); repeat (2) @(negedge clk);
    check("gap_ready", 32'(in_ready), 32'd1);
    check("gap_valid", 32'(out_valid), 32'd0);
    push(0, 1'b0);  repeat (2) @(negedge clk);
    push(31, 1'b1); repeat (2) @(negedge clk);
    push(31, 1'b0); repeat (2) @(negedge clk);
    push(7, 1'b0);
    pop("dsc0", 63, 1'b0);
    pop("dsc1", 31, 1'b0);
    pop("dsc2", 31, 1'b0);
    pop("dsc3", 7, 1'b0);
    pop("dsc4", 0, 1'b1);
    idle_check("dsc_end");

    // Backpressure on the first element (0).
    push(9, 1'b0); push(0, 1'b0); push(9, 1'b0); push(2, 1'b0);
    out_ready = 1'b0;
    push(5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_num",   32'(out_num),   32'd0);
      check("bp_last",  32'(out_last),  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    pop("bp0", 0, 1'b0);
    pop("bp1", 2, 1'b0);
    pop("bp2", 5, 1'b0);
    pop("bp3", 9, 1'b0);
    pop("bp4", 9, 1'b1);
    idle_check("bp_end");

    // Reset mid-load discards the partial batch.
    push(40, 1'b1); push(50, 1'b1); push(60, 1'b1);
    reset_pulse("rst_load");
    idle_check("rst_load_after");
    push(5, 1'b0); push(4, 1'b0); push(3, 1'b0); push(2, 1'b0); push(1, 1'b0);
    pop("rl0", 1, 1'b0);
    pop("rl1", 2, 1'b0);
    pop("rl2", 3, 1'b0);
    pop("rl3", 4, 1'b0);
    pop("rl4", 5, 1'b1);
    idle_check("rl_end");

    // Reset mid-output: no further output follows.
    push(8, 1'b0); push(6, 1'b0); push(4, 1'b0); push(2, 1'b0); push(0, 1'b0);
    pop("ro0", 0, 1'b0);
    pop("ro1", 2, 1'b0);
    reset_pulse("rst_out");
    idle_check("rst_out_after");
    @(negedge clk);
    idle_check("rst_out_later");

    // Boundary values.
    for (int k = 0; k < 5; k++) push(63, 1'b0);
    for (int k = 0; k < 5; k++) pop("max", 63, (k == 4));
    idle_check("max_end");
    push(0, 1'b0); push(63, 1'b0); push(0, 1'b0); push(63, 1'b0); push(0, 1'b0);
    pop("mix0", 0, 1'b0);
    pop("mix1", 0, 1'b0);
    pop("mix2", 0, 1'b0);
    pop("mix3", 63, 1'b0);
    pop("mix4", 63, 1'b1);

    // in_valid held high through OUT is ignored; next batch starts after out_last.
    push(50, 1'b0); push(40, 1'b0); push(30, 1'b0); push(20, 1'b0); push(10, 1'b0);
    in_valid = 1'b1;
    in_num   = 6'd7;
    in_mode  = 1'b1;
    pop("hold0", 10, 1'b0);
    pop("hold1", 20, 1'b0);
    pop("hold2", 30, 1'b0);
    pop("hold3", 40, 1'b0);
    pop("hold4", 50, 1'b1);
    idle_check("hold_end");
    @(negedge clk);
    // 7 accepted in descending mode; four more complete the batch.
    push(1, 1'b0); push(2, 1'b0); push(3, 1'b0); push(4, 1'b0);
    pop("nb0", 7, 1'b0);
    pop("nb1", 4, 1'b0);
    pop("nb2", 3, 1'b0);
    pop("nb3", 2, 1'b0);
    pop("nb4", 1, 1'b1);
    idle_check("nb_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
